// File: rtl/ltl_sched_pkg.sv
// Shared types for the LTL automaton frame scheduler: FSM states, the per-frame
// result record and the "no hit yet" position marker.
package ltl_sched_pkg;

  localparam int DEF_IDX_W = 2;
  localparam int DEF_RPT_W = 4;
  localparam int DEF_POS_W = 16;

  localparam logic [DEF_POS_W-1:0] POS_NONE = {DEF_POS_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    STREAM,
    DRAIN,
    RESULT,
    DISCARD
  } state_e;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] req_id;
    logic [DEF_RPT_W-1:0] hits;
    logic [DEF_POS_W-1:0] first_pos;
    logic [DEF_POS_W-1:0] len;
    logic                 aborted;
  } result_t;

endpackage

// File: rtl/ltl_monitor_frame_scheduler_arb.sv
// Combinational round-robin arbiter: the first active request at or after the
// pointer wins; returns the one-hot grant, its index and an any-request flag.
module ltl_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               valid_o
);

  always_comb begin
    logic found;
    int   idx;
    found       = 1'b0;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ltl_monitor_frame_scheduler.sv
// Time-shares one LTL automaton between NUM_REQ requesters, one whole frame at a
// time. Optional stall timeout/discard path is enabled by LTL_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | automaton held in reset, arbitrating for the next frame
// FLUSH   | automaton reset for FLUSH_CYCLES, frame accumulators cleared
// STREAM  | granted requester's symbols stepped into the automaton
// DISCARD | timed-out frame: beats through last are dropped
// DRAIN   | waiting RPT_LAT cycles for the final symbol's report
// RESULT  | result record presented until accepted
module ltl_monitor_frame_scheduler
  import ltl_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_RPT      = 4,
  parameter int POS_W        = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int RPT_LAT      = 1,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_symbol,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ate_reset,
  output logic                       ate_run,
  output logic [7:0]                 ate_symbols,
  input  logic [NUM_RPT-1:0]         ate_report,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_req_id,
  output logic [NUM_RPT-1:0]         res_hits,
  output logic [POS_W-1:0]           res_first_pos,
  output logic [POS_W-1:0]           res_len,
  output logic                       res_aborted,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (FLUSH_CYCLES > RPT_LAT) ? FLUSH_CYCLES : RPT_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [POS_W-1:0] POS_ALL = {POS_W{1'b1}};

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, ptr_q;
  logic [NUM_REQ-1:0]   grant_oh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_RPT-1:0]   hits_q;
  logic [POS_W-1:0]     first_pos_q, len_q;
  logic [RPT_LAT-1:0]   pipe_vld_q;
  logic [POS_W-1:0]     pipe_pos_q [RPT_LAT];

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 g_valid, g_last, accept, cnt_zero;

  ltl_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  assign g_valid  = |(req_valid & grant_oh_q);
  assign g_last   = |(req_last & grant_oh_q);
  assign accept   = (state_q == STREAM) && g_valid;
  assign cnt_zero = (cnt_q == '0);

`ifdef LTL_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;
  logic               aborted_q, timeout;

  // Down-counter of remaining stall cycles; terminal count fires the abort.
  assign timeout = (state_q == STREAM) && !g_valid && (stall_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= STALL_W'(TIMEOUT_CYC - 1);
      aborted_q <= 1'b0;
    end else begin
      if (state_q == FLUSH || accept) stall_q <= STALL_W'(TIMEOUT_CYC - 1);
      else if (state_q == STREAM && stall_q != '0) stall_q <= stall_q - 1'b1;
      if (state_q == FLUSH) aborted_q <= 1'b0;
      else if (timeout) aborted_q <= 1'b1;
    end
  end

  assign res_aborted = aborted_q;
`else
  assign res_aborted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = FLUSH;
      FLUSH:   if (cnt_zero) state_d = STREAM;
      STREAM: begin
        if (accept && g_last) state_d = DRAIN;
`ifdef LTL_SCHED_TIMEOUT_EN
        else if (timeout) state_d = DISCARD;
`endif
      end
`ifdef LTL_SCHED_TIMEOUT_EN
      DISCARD: if (g_valid && g_last) state_d = DRAIN;
`endif
      DRAIN:   if (cnt_zero) state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    ate_reset   = 1'b0;
    ate_run     = 1'b0;
    ate_symbols = '0;
    res_valid   = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE, FLUSH: ate_reset = 1'b1;
      STREAM: begin
        req_ready   = grant_oh_q;
        ate_run     = g_valid;
        ate_symbols = req_symbol[{grant_q, 3'b000} +: 8];
      end
      DISCARD: req_ready = grant_oh_q;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      grant_oh_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      hits_q      <= '0;
      first_pos_q <= POS_ALL;
      len_q       <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RPT_LAT; i++) pipe_pos_q[i] <= '0;
    end else begin
      // Each accepted symbol's position travels alongside its pending report.
      pipe_vld_q[0] <= accept;
      pipe_pos_q[0] <= len_q;
      for (int i = 1; i < RPT_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_pos_q[i] <= pipe_pos_q[i-1];
      end

      case (state_q)
        IDLE: if (arb_valid) begin
          grant_q    <= arb_idx;
          grant_oh_q <= arb_grant;
          cnt_q      <= CNT_W'(FLUSH_CYCLES - 1);
        end
        FLUSH, DRAIN: if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
        STREAM:  if (accept && g_last) cnt_q <= CNT_W'(RPT_LAT - 1);
        DISCARD: if (g_valid && g_last) cnt_q <= CNT_W'(RPT_LAT - 1);
        RESULT:  if (res_ready) ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase

      if (state_q == FLUSH) begin
        hits_q      <= '0;
        first_pos_q <= POS_ALL;
        len_q       <= '0;
      end else begin
        if (pipe_vld_q[RPT_LAT-1] && |ate_report) begin
          hits_q <= hits_q | ate_report;
          if (first_pos_q == POS_ALL) first_pos_q <= pipe_pos_q[RPT_LAT-1];
        end
        if (accept && len_q != POS_ALL) len_q <= len_q + 1'b1;
      end
    end
  end

  assign res_req_id    = grant_q;
  assign res_hits      = hits_q;
  assign res_first_pos = first_pos_q;
  assign res_len       = len_q;

endmodule
